// File: rtl/bus_mux_pkg.sv
// Shared project constants for the bus multiplexer family.
// The default word width matches the processor datapath.
package bus_mux_pkg;

    localparam int ARQUITECTURE_BITS = 32;

endpackage

// File: rtl/bus_mux_reg.sv
// Output register for the word multiplexer, cleared asynchronously by reset.
// It lives in its own module so that the mux core stays purely combinational.
module bus_mux_reg #(
    parameter int BUS_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUS_SIZE-1:0] d,
    output logic [BUS_SIZE-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/bus_mux.sv
// N-to-1 word multiplexer with a binary channel index and a zero-latency output.
// It also provides a registered copy of that output for pipeline-stage boundaries.
module bus_mux
    import bus_mux_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int BUS_SIZE = ARQUITECTURE_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          selector,
    input  logic [CHANNELS*BUS_SIZE-1:0] data_in,
    output logic [BUS_SIZE-1:0]          data_out,
    output logic [BUS_SIZE-1:0]          data_out_reg
);

    if (CHANNELS < 2) begin : g_bad_channels
        $error("bus_mux: CHANNELS must be at least 2");
    end
    if (BUS_SIZE < 1) begin : g_bad_bus_size
        $error("bus_mux: BUS_SIZE must be at least 1");
    end

    logic [BUS_SIZE-1:0] words [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_word
        assign words[gi] = data_in[BUS_SIZE*gi +: BUS_SIZE];
    end

    // An out-of-range index matches no channel, so the output falls back to zeros.
    always_comb begin
        data_out = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (selector == CHANNELS'(k)) begin
                data_out = words[k];
            end
        end
    end

    bus_mux_reg #(
        .BUS_SIZE(BUS_SIZE)
    ) u_out_reg (
        .clk  (clk),
        .reset(reset),
        .d    (data_out),
        .q    (data_out_reg)
    );

endmodule

// File: tb/tb_bus_mux.sv
// Randomised and directed bench for bus_mux with 2- and 4-channel instances.
// Expectations come from a slice-or-zero reference model and a one-cycle delay model.
module tb_bus_mux;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   sel2;
    logic [63:0]  din2;
    logic [31:0]  out2, out2_reg;
    logic [3:0]   sel4;
    logic [127:0] din4;
    logic [31:0]  out4, out4_reg;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_mux #(.CHANNELS(2), .BUS_SIZE(32)) u_mux2 (
        .clk         (clk),
        .reset       (reset),
        .selector    (sel2),
        .data_in     (din2),
        .data_out    (out2),
        .data_out_reg(out2_reg)
    );

    bus_mux #(.CHANNELS(4), .BUS_SIZE(32)) u_mux4 (
        .clk         (clk),
        .reset       (reset),
        .selector    (sel4),
        .data_in     (din4),
        .data_out    (out4),
        .data_out_reg(out4_reg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=%08h", tag, got);
        end
    endtask

    // Word `sel` of the flat bus when it names a real channel, zero otherwise.
    function automatic logic [31:0] ref_mux(input int channels, input int sel,
                                            input logic [127:0] bus);
        logic [31:0] w;
        w = 32'h0;
        if (sel < channels) w = bus[32*sel +: 32];
        return w;
    endfunction

    logic [31:0] exp2, exp4;

    initial begin
        void'($urandom(32'd20240601));
        reset = 1'b1;
        sel2  = 2'd0;
        din2  = {32'hDEADBEEF, 32'h12345678};
        sel4  = 4'd2;
        din4  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // Register holds zero through clock activity while reset is high.
        repeat (3) @(posedge clk);
        #1;
        check("reset_reg2", out2_reg, 32'h0);
        check("reset_reg4", out4_reg, 32'h0);

        // Combinational path is live regardless of reset.
        #10 check("c2_sel0", out2, 32'h12345678);
        sel2 = 2'd1;
        #10 check("c2_sel1", out2, 32'hDEADBEEF);
        for (int s = 0; s < 4; s++) begin
            sel4 = 4'(s);
            #1 check($sformatf("c4_sweep%0d", s), out4, ref_mux(4, s, din4));
        end
        sel4 = 4'd5;
        #1 check("c4_oob5", out4, 32'h0);
        sel2 = 2'd3;
        #1 check("c2_oob3", out2, 32'h0);

        // Release reset with channel 2 selected.
        sel4 = 4'd2;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("reg4_first_load", out4_reg, 32'h33333333);
        #1 sel4 = 4'd3;
        #1 check("reg4_hold", out4_reg, 32'h33333333);
        check("c4_sel3", out4, 32'h44444444);
        @(posedge clk);
        #1 check("reg4_next_load", out4_reg, 32'h44444444);

        // Asynchronous clear between edges leaves the combinational path alone.
        #2 reset = 1'b1;
        #1 check("async_clear_reg4", out4_reg, 32'h0);
        check("async_clear_reg2", out2_reg, 32'h0);
        check("async_comb4", out4, 32'h44444444);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic on both instances; register must lag the comb output by one edge.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            din2 = {$urandom(), $urandom()};
            din4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            sel2 = 2'($urandom_range(0, 3));
            sel4 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                               : 4'($urandom_range(0, 3));
            exp2 = ref_mux(2, int'(sel2), {64'h0, din2});
            exp4 = ref_mux(4, int'(sel4), din4);
            #1;
            check($sformatf("rnd%0d_c2", i), out2, exp2);
            check($sformatf("rnd%0d_c4", i), out4, exp4);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_r2", i), out2_reg, exp2);
            check($sformatf("rnd%0d_r4", i), out4_reg, exp4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
